// File: rtl/fir_out_drain.sv
// fir_out_drain: consumer end of the FIR output interface.
// Decimates the wide signed FIR result by DECIM, requantises it to OUT_W bits
// with saturation, and queues the samples in a first-word-fall-through FIFO
// behind a valid/ready port.
// Optional build macro: FIR_DRAIN_ROUND_EN selects round-half-up requantisation;
// when it is undefined the shift truncates toward minus infinity.
//
// Handshake: out_valid is high whenever the FIFO holds a sample and out_data
// then shows the head entry; a sample is popped at the posedge where
// out_valid && out_ready. out_ready while out_valid is low has no effect.
// The input side has no backpressure: in_valid samples are taken every cycle.
module fir_out_drain #(
    parameter int IN_W       = 35,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 11,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rest,
    input  logic [IN_W-1:0]               in_data,
    input  logic                          in_valid,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          sat_flag,
    output logic                          ovf_flag
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);

`ifdef FIR_DRAIN_ROUND_EN
    localparam logic signed [IN_W:0] RND_ADD = (IN_W + 1)'(1) <<< (SHIFT - 1);
`else
    localparam logic signed [IN_W:0] RND_ADD = '0;
`endif
    localparam logic signed [IN_W:0] Q_MAX = (IN_W + 1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W:0] Q_MIN = (IN_W + 1)'(-(64'sd1 <<< (OUT_W - 1)));

    // Decimation phase and stage-1 pipeline registers
    logic [PW-1:0]    r_phase;
    logic             r_pipe_valid;
    logic [OUT_W-1:0] r_pipe_data;

    // FIFO storage; pointers carry one extra MSB to tell full from empty
    logic [OUT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic                    w_keep;
    logic signed [IN_W:0]    w_ext;
    logic signed [IN_W:0]    w_rnd;
    logic signed [IN_W:0]    w_q;
    logic                    w_hi;
    logic                    w_lo;
    logic [OUT_W-1:0]        w_sample;
    logic [AW:0]             w_level;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;

    // One extra bit of headroom so the rounding add can never wrap
    assign w_keep   = in_valid && (r_phase == '0);
    assign w_ext    = {in_data[IN_W-1], in_data};
    assign w_rnd    = w_ext + RND_ADD;
    assign w_q      = w_rnd >>> SHIFT;
    assign w_hi     = (w_q > Q_MAX);
    assign w_lo     = (w_q < Q_MIN);
    assign w_sample = w_hi ? Q_MAX[OUT_W-1:0] :
                      w_lo ? Q_MIN[OUT_W-1:0] : w_q[OUT_W-1:0];

    // A push into a full FIFO still succeeds when the head leaves the same cycle
    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_level == (AW + 1)'(FIFO_DEPTH));
    assign w_empty  = (w_level == '0);
    assign w_pop    = !w_empty && out_ready;
    assign w_push   = r_pipe_valid && (!w_full || w_pop);
    assign w_drop   = r_pipe_valid && w_full && !w_pop;

    assign out_valid = !w_empty;
    assign out_data  = out_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
    assign level     = w_level;

    // Decimation phase: advances on every valid input, wraps at DECIM-1
    always_ff @(posedge clk) begin
        if (rest) begin
            r_phase <= '0;
        end else if (in_valid) begin
            r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + PW'(1);
        end
    end

    // Stage 1: register the requantised kept sample and latch saturation
    always_ff @(posedge clk) begin
        if (rest) begin
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
            sat_flag     <= 1'b0;
        end else begin
            r_pipe_valid <= w_keep;
            if (w_keep) begin
                r_pipe_data <= w_sample;
                if (w_hi || w_lo) begin
                    sat_flag <= 1'b1;
                end
            end
        end
    end

    // Stage 2: FIFO pointer update and sticky overflow on a dropped sample
    always_ff @(posedge clk) begin
        if (rest) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
            end
            if (w_drop) begin
                ovf_flag <= 1'b1;
            end
        end
    end

    // FIFO storage write; contents need no reset because out_data is gated
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_pipe_data;
        end
    end

endmodule
